// File: rtl/cp0_intr_ctrl_pkg.sv
// cp0_defs: shared CP0 register numbers, Status/Cause bit positions, vector address
package cp0_defs;
  localparam logic [31:0] HANDLER_PC = 32'h8000_0180;
  localparam int NUM_EXT = 5;
  localparam logic [4:0] REG_COUNT = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam int ST_IE = 0;
  localparam int ST_EXL = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int IP_LO = 8;
  localparam int IP_HI = 15;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
endpackage

// File: rtl/cp0_intr_ctrl_if.sv
// cp0_intr_ctrl_if: machine<->CP0 bus (MFC0/MTC0/ERET, external irqs, EPC, interrupt decision)
interface cp0_intr_ctrl_if;
  import cp0_defs::*;
  logic [4:0] regnum;
  logic [31:0] wr_data;
  logic [31:0] next_pc;
  logic MTC0;
  logic ERET;
  logic [NUM_EXT-1:0] ext_irq;
  logic [31:0] rd_data;
  logic [31:0] EPC;
  logic TakenInterrupt;
  modport master (output regnum, wr_data, next_pc, MTC0, ERET, ext_irq, input rd_data, EPC, TakenInterrupt);
  modport slave (input regnum, wr_data, next_pc, MTC0, ERET, ext_irq, output rd_data, EPC, TakenInterrupt);
endinterface

// File: rtl/cp0_intr_ctrl_timer.sv
// cp0_timer: Count/Compare timer; in regnum/wr_data/mtc0, out count/compare/timer_pending
module cp0_timer
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  regnum,
  input  logic [31:0] wr_data,
  input  logic        mtc0,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pending
);
  logic wr_count, wr_compare;
  assign wr_count = mtc0 && regnum == REG_COUNT;
  assign wr_compare = mtc0 && regnum == REG_COMPARE;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      compare <= '1;
      timer_pending <= 1'b0;
    end else begin
      count <= wr_count ? wr_data : count + 32'd1;
      compare <= wr_compare ? wr_data : compare;
      timer_pending <= !wr_compare && (timer_pending || count == compare);
    end
  end
endmodule

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 Status/Cause/EPC + timer and interrupt decision; ports clk, reset, bus (slave: regnum, wr_data, next_pc, MTC0, ERET, ext_irq -> rd_data, EPC, TakenInterrupt)
module cp0_intr_ctrl
  import cp0_defs::*;
(
  input  logic clk,
  input  logic reset,
  cp0_intr_ctrl_if.slave bus
);
  logic [31:0] status, epc, count, compare, cause;
  logic timer_pending, taken, wr_status, wr_epc;
  cp0_timer u_timer (
    .clk(clk),
    .reset(reset),
    .regnum(bus.regnum),
    .wr_data(bus.wr_data),
    .mtc0(bus.MTC0),
    .count(count),
    .compare(compare),
    .timer_pending(timer_pending)
  );
  assign cause = {16'b0, timer_pending, bus.ext_irq, 10'b0};
  assign wr_status = bus.MTC0 && bus.regnum == REG_STATUS;
  assign wr_epc = bus.MTC0 && bus.regnum == REG_EPC;
  assign taken = !reset && status[ST_IE] && !status[ST_EXL] && !bus.ERET &&
                 |(cause[IP_HI:IP_LO] & status[ST_IM_HI:ST_IM_LO]);
  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
      epc <= '0;
    end else begin
      status <= wr_status ? (status & ~STATUS_WMASK) | (bus.wr_data & STATUS_WMASK) : status;
      if (bus.ERET) status[ST_EXL] <= 1'b0;
      if (taken) status[ST_EXL] <= 1'b1;
      epc <= taken ? bus.next_pc : wr_epc ? bus.wr_data : epc;
    end
  end
  always_comb begin
    bus.rd_data = bus.regnum == REG_COUNT   ? count   :
                  bus.regnum == REG_COMPARE ? compare :
                  bus.regnum == REG_STATUS  ? status  :
                  bus.regnum == REG_CAUSE   ? cause   :
                  bus.regnum == REG_EPC     ? epc     : '0;
  end
  assign bus.EPC = epc;
  assign bus.TakenInterrupt = taken;
endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb_cp0_intr_ctrl: directed plus random stimulus checked against a behavioural CP0 model
module tb_cp0_intr_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  cp0_intr_ctrl_if bus();
  cp0_intr_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_status, m_epc, m_count, m_compare;
  bit m_pend;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_status = 0; m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_pend = 0;
  endtask
  task automatic cycle(output bit t);
    logic [31:0] cause, exp_rd;
    logic [7:0] ip, im;
    bit t_exp, wr;
    cause = {16'b0, m_pend, bus.ext_irq, 10'b0};
    ip = cause[15:8];
    im = m_status[15:8];
    t_exp = !reset && m_status[0] && !m_status[1] && !bus.ERET && ((ip & im) != 0);
    case (bus.regnum)
      5'd9: exp_rd = m_count;
      5'd11: exp_rd = m_compare;
      5'd12: exp_rd = m_status;
      5'd13: exp_rd = cause;
      5'd14: exp_rd = m_epc;
      default: exp_rd = 0;
    endcase
    #1;
    check("rd_data", bus.rd_data, exp_rd);
    check("epc", bus.EPC, m_epc);
    check("taken", {31'b0, bus.TakenInterrupt}, {31'b0, t_exp});
    t = bus.TakenInterrupt;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      wr = bus.MTC0;
      if (m_count == m_compare) m_pend = 1;
      if (wr && bus.regnum == 11) begin m_pend = 0; m_compare = bus.wr_data; end
      m_count = (wr && bus.regnum == 9) ? bus.wr_data : m_count + 1;
      if (wr && bus.regnum == 12) m_status = (m_status & ~32'h0000_FF03) | (bus.wr_data & 32'h0000_FF03);
      if (wr && bus.regnum == 14) m_epc = bus.wr_data;
      if (bus.ERET) m_status[1] = 0;
      if (t_exp) begin m_epc = bus.next_pc; m_status[1] = 1; end
    end
    #1;
  endtask
  task automatic op(input logic [4:0] r, input logic [31:0] w, input bit mt, input bit er);
    bit t;
    bus.regnum = r; bus.wr_data = w; bus.MTC0 = mt; bus.ERET = er;
    cycle(t);
  endtask
  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string tag);
    bus.regnum = r; bus.MTC0 = 0; bus.ERET = 0;
    #1;
    check(tag, bus.rd_data, exp);
  endtask
  task automatic wait_taken(input int budget, input string tag);
    bit t = 0;
    bus.regnum = 13; bus.MTC0 = 0; bus.ERET = 0;
    for (int i = 0; i < budget && !t; i++) cycle(t);
    check(tag, {31'b0, t}, 32'd1);
  endtask
  initial begin
    bit t;
    logic [4:0] regs [6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    reset = 1; bus.regnum = 0; bus.wr_data = 0; bus.MTC0 = 0; bus.ERET = 0;
    bus.ext_irq = 0; bus.next_pc = 0;
    model_reset();
    @(posedge clk); #1;
    cycle(t); cycle(t);
    reset = 0;
    peek(9, 0, "rst_count");
    peek(12, 0, "rst_status");
    peek(13, 0, "rst_cause");
    peek(14, 0, "rst_epc");
    peek(11, 32'hFFFF_FFFF, "rst_compare");
    check("rst_taken", {31'b0, bus.TakenInterrupt}, 0);
    cycle(t);
    op(11, 5, 1, 0);
    op(12, 32'h8001, 1, 0);
    op(9, 0, 1, 0);
    bus.next_pc = 32'h0040_0010;
    wait_taken(20, "timer5_taken");
    peek(14, 32'h0040_0010, "irq_epc");
    peek(12, 32'h8003, "irq_status");
    peek(13, 32'h8000, "irq_cause");
    check("irq_exl_blocks", {31'b0, bus.TakenInterrupt}, 0);
    op(11, 100, 1, 0);
    peek(13, 0, "cmp_clear");
    op(0, 0, 0, 1);
    bus.next_pc = 32'h0040_0100;
    wait_taken(150, "timer100_taken");
    op(11, 1000, 1, 0);
    op(0, 0, 0, 1);
    bus.ext_irq = 5'b00001;
    op(12, 32'h0401, 1, 0);
    peek(13, 32'h0400, "ext_cause");
    check("ext_taken", {31'b0, bus.TakenInterrupt}, 1);
    cycle(t);
    op(12, 32'h0003, 1, 0);
    op(0, 0, 0, 1);
    peek(12, 32'h0001, "masked_status");
    check("ext_masked", {31'b0, bus.TakenInterrupt}, 0);
    cycle(t);
    op(12, 32'h0401, 1, 0);
    bus.regnum = 12; bus.MTC0 = 0; bus.ERET = 1;
    #1;
    check("eret_suppress", {31'b0, bus.TakenInterrupt}, 0);
    cycle(t);
    peek(12, 32'h0401, "eret_exl_clear");
    check("ext_after_eret", {31'b0, bus.TakenInterrupt}, 1);
    cycle(t);
    bus.ext_irq = 0;
    op(0, 0, 0, 1);
    op(11, 0, 1, 0);
    op(9, 32'hFFFF_FFFE, 1, 0);
    peek(9, 32'hFFFF_FFFE, "wrap_load"); cycle(t);
    peek(9, 32'hFFFF_FFFF, "wrap_max"); cycle(t);
    peek(9, 0, "wrap_zero"); cycle(t);
    peek(13, 32'h8000, "wrap_pend"); cycle(t);
    op(11, 30, 1, 0);
    op(9, 29, 1, 0);
    op(0, 0, 0, 0);
    peek(9, 30, "clr_setup");
    op(11, 500, 1, 0);
    peek(13, 0, "clear_beats_set");
    cycle(t);
    op(12, 32'h8001, 1, 0);
    op(11, 40, 1, 0);
    op(9, 38, 1, 0);
    bus.next_pc = 32'h0040_0200;
    wait_taken(10, "pre_reset_taken");
    peek(13, 32'h8000, "pre_reset_pend");
    reset = 1;
    op(13, 0, 0, 0);
    reset = 0;
    peek(9, 0, "mid_rst_count");
    peek(12, 0, "mid_rst_status");
    peek(13, 0, "mid_rst_cause");
    peek(14, 0, "mid_rst_epc");
    peek(11, 32'hFFFF_FFFF, "mid_rst_compare");
    cycle(t);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r;
      logic [31:0] w;
      r = regs[$urandom_range(0, 5)];
      w = $urandom;
      if (r == 9 && $urandom_range(0, 1) == 0) w = m_compare - $urandom_range(0, 8);
      if (r == 11 && $urandom_range(0, 1) == 0) w = m_count + $urandom_range(0, 8);
      reset = $urandom_range(0, 199) == 0;
      bus.ext_irq = $urandom_range(0, 4) == 0 ? 5'($urandom) : 5'b0;
      bus.next_pc = $urandom;
      op(r, w, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
